// File: rtl/current_calc_scheduler.sv
// Time-multiplexes one registered input-current calculator across N neurons.
// Issues one neuron per cycle and captures each result one cycle after its issue.
module current_calc_scheduler #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int Nbits = 4,
    parameter int IDXW  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [M-1:0]           input_spikes,
    input  logic [N*M*Nbits-1:0]   weights_all,
    output logic [M-1:0]           calc_spikes,
    output logic [M*Nbits-1:0]     calc_weights,
    output logic                   calc_enable,
    input  logic [Nbits-1:0]       calc_current,
    output logic [N*Nbits-1:0]     currents,
    output logic [IDXW-1:0]        neuron_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t          state_reg;
    logic [M-1:0]    spk_reg;
    logic [IDXW-1:0] idx_reg;
    logic            en_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            overrun_reg;
    logic            zero_start;

    // An all-zero spike vector yields zero current everywhere, so skip the calculator.
    assign zero_start = start && (state_reg == IDLE) && (input_spikes == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            spk_reg     <= '0;
            idx_reg     <= '0;
            en_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start && state_reg != IDLE)
                overrun_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        spk_reg <= input_spikes;
                        if (input_spikes == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                            idx_reg   <= '0;
                            en_reg    <= 1'b1;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= DRAIN;
                        idx_reg   <= '0;
                        en_reg    <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    state_reg <= DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Neuron gi's result arrives while idx gi+1 is being issued, or in DRAIN for the last one.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cur
            logic [Nbits-1:0] cur_reg;
            logic             cap;

            assign cap = ((state_reg == ISSUE) && ({1'b0, idx_reg} == (IDXW+1)'(gi + 1)))
                       || ((state_reg == DRAIN) && (gi == N - 1));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    cur_reg <= '0;
                else if (zero_start)
                    cur_reg <= '0;
                else if (cap)
                    cur_reg <= calc_current;
            end

            assign currents[gi*Nbits +: Nbits] = cur_reg;
        end
    endgenerate

    always_comb begin
        calc_weights = '0;
        for (int k = 0; k < N; k++) begin
            if (state_reg == ISSUE && idx_reg == IDXW'(k))
                calc_weights = weights_all[k*M*Nbits +: M*Nbits];
        end
    end

    assign calc_spikes = spk_reg;
    assign calc_enable = en_reg;
    assign neuron_idx  = idx_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_current_calc_scheduler.sv
// Scoreboard bench for current_calc_scheduler with a saturating calculator attached;
// covers an N=4 instance with directed and random timesteps, plus an N=1 instance.
module tb_current_calc_scheduler;

    localparam int N  = 4;
    localparam int M  = 4;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic                start = 1'b0;
    logic [M-1:0]        input_spikes = '0;
    logic [N*M*NB-1:0]   weights_all = '0;
    logic [M-1:0]        calc_spikes;
    logic [M*NB-1:0]     calc_weights;
    logic                calc_enable;
    logic [NB-1:0]       calc_current;
    logic [N*NB-1:0]     currents;
    logic [1:0]          neuron_idx;
    logic                busy, done, overrun;

    // N=1 instance
    logic                start1 = 1'b0;
    logic [M-1:0]        spikes1 = '0;
    logic [M*NB-1:0]     weights1 = '0;
    logic [M-1:0]        calc_spikes1;
    logic [M*NB-1:0]     calc_weights1;
    logic                calc_enable1;
    logic [NB-1:0]       calc_current1;
    logic [NB-1:0]       currents1;
    logic [0:0]          neuron_idx1;
    logic                busy1, done1, overrun1;

    current_calc_scheduler #(.N(N), .M(M), .Nbits(NB), .IDXW(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .input_spikes(input_spikes),
        .weights_all(weights_all), .calc_spikes(calc_spikes), .calc_weights(calc_weights),
        .calc_enable(calc_enable), .calc_current(calc_current), .currents(currents),
        .neuron_idx(neuron_idx), .busy(busy), .done(done), .overrun(overrun)
    );

    current_calc_scheduler #(.N(1), .M(M), .Nbits(NB), .IDXW(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .input_spikes(spikes1),
        .weights_all(weights1), .calc_spikes(calc_spikes1), .calc_weights(calc_weights1),
        .calc_enable(calc_enable1), .calc_current(calc_current1), .currents(currents1),
        .neuron_idx(neuron_idx1), .busy(busy1), .done(done1), .overrun(overrun1)
    );

    // Calculator: registered dot product of spikes and weights, saturating at 7.
    function automatic logic [NB-1:0] calc_fn(input logic [M-1:0] s, input logic [M*NB-1:0] w);
        int sum;
        sum = 0;
        for (int i = 0; i < M; i++)
            if (s[i]) sum += int'(w[i*NB +: NB]);
        return (sum > 7) ? NB'(7) : NB'(sum);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            calc_current  <= '0;
            calc_current1 <= '0;
        end else begin
            if (calc_enable)  calc_current  <= calc_fn(calc_spikes, calc_weights);
            if (calc_enable1) calc_current1 <= calc_fn(calc_spikes1, calc_weights1);
        end
    end

    // Reference model state
    int w_tab [N][M];
    int w1_tab [M];

    function automatic logic [15:0] ref_currents(input logic [M-1:0] s, input bit one);
        logic [15:0] r;
        int acc;
        r = '0;
        for (int k = 0; k < (one ? 1 : N); k++) begin
            acc = 0;
            for (int i = 0; i < M; i++)
                acc += (s[i] ? 1 : 0) * (one ? w1_tab[i] : w_tab[k][i]);
            if (acc > 7) acc = 7;
            r[k*4 +: 4] = 4'(acc);
        end
        return r;
    endfunction

    typedef struct {
        logic [15:0] cur;
        int          done_cyc;
        logic [3:0]  spk;
        logic [63:0] w;
        bit          zero;
    } sb_t;

    sb_t sbq[$];
    sb_t sbq1[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit ovr_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor
    int en_cnt = 0;
    int busy_cnt = 0;
    logic [15:0] hold_exp = '0;
    logic [3:0]  hold1_exp = '0;

    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            sbq.delete();
            sbq1.delete();
            en_cnt = 0;
            busy_cnt = 0;
            hold_exp = '0;
            hold1_exp = '0;
            chk("rst_currents", 64'(currents), 64'h0);
            chk("rst_busy", 64'(busy), 64'h0);
            chk("rst_done", 64'(done), 64'h0);
            chk("rst_calc_enable", 64'(calc_enable), 64'h0);
            chk("rst_neuron_idx", 64'(neuron_idx), 64'h0);
            chk("rst_overrun", 64'(overrun), 64'h0);
            chk("rst_currents1", 64'(currents1), 64'h0);
        end else begin
            chk("overrun", 64'(overrun), 64'(ovr_exp));
            if (calc_enable) begin
                if (sbq.size() == 0 || en_cnt >= N) begin
                    chk("unexpected_enable", 64'(calc_enable), 64'h0);
                end else begin
                    chk("neuron_idx", 64'(neuron_idx), 64'(en_cnt));
                    chk("calc_weights", 64'(calc_weights), 64'(sbq[0].w[en_cnt*16 +: 16]));
                    chk("calc_spikes", 64'(calc_spikes), 64'(sbq[0].spk));
                end
                en_cnt++;
            end else begin
                chk("idx_not_issuing", 64'(neuron_idx), 64'h0);
                chk("weights_not_issuing", 64'(calc_weights), 64'h0);
            end
            if (busy) busy_cnt++;

            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("currents", 64'(currents), 64'(e.cur));
                    chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    chk("enable_cycles", 64'(en_cnt), 64'(e.zero ? 0 : N));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.zero ? 0 : N + 1));
                    hold_exp = e.cur;
                end
                en_cnt = 0;
                busy_cnt = 0;
            end else if (sbq.size() > 0 && cyc > sbq[0].done_cyc) begin
                compared++;
                mismatched++;
                $display("FAIL done_timeout: no done seen, expected in cycle %0d (now %0d)",
                         sbq[0].done_cyc, cyc);
                void'(sbq.pop_front());
                en_cnt = 0;
                busy_cnt = 0;
            end else if (sbq.size() == 0 && !busy) begin
                chk("currents_hold", 64'(currents), 64'(hold_exp));
            end

            chk("overrun1", 64'(overrun1), 64'h0);
            chk("neuron_idx1", 64'(neuron_idx1), 64'h0);
            if (done1) begin
                if (sbq1.size() == 0) begin
                    chk("unexpected_done1", 64'(done1), 64'h0);
                end else begin
                    e = sbq1.pop_front();
                    chk("currents1", 64'(currents1), 64'(e.cur[3:0]));
                    chk("done_cycle1", 64'(cyc), 64'(e.done_cyc));
                    hold1_exp = e.cur[3:0];
                end
            end else if (sbq1.size() > 0 && cyc > sbq1[0].done_cyc) begin
                compared++;
                mismatched++;
                $display("FAIL done1_timeout: no done seen, expected in cycle %0d (now %0d)",
                         sbq1[0].done_cyc, cyc);
                void'(sbq1.pop_front());
            end else if (sbq1.size() == 0 && !busy1) begin
                chk("currents1_hold", 64'(currents1), 64'(hold1_exp));
            end
        end
    end

    // Driver
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic apply_weights();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < M; i++)
                weights_all[(k*M + i)*NB +: NB] = NB'(w_tab[k][i]);
    endtask

    // ovr_at / rst_at: cycle (relative to start) for a stray start / reset, 0 = none.
    task automatic timestep(input logic [3:0] spk, input int ovr_at, input int rst_at);
        sb_t e;
        int c, lat;
        @(negedge clk);
        apply_weights();
        lat = (spk == 4'b0) ? 1 : N + 2;
        c = cyc;
        e.cur = ref_currents(spk, 1'b0);
        e.done_cyc = c + lat;
        e.spk = spk;
        e.w = weights_all;
        e.zero = (spk == 4'b0);
        input_spikes = spk;
        sbq.push_back(e);
        $display("timestep: spikes=%b weights=%h expect currents=%h at cycle %0d ovr_at=%0d rst_at=%0d",
                 spk, weights_all, e.cur, e.done_cyc, ovr_at, rst_at);
        pulse_start();
        input_spikes = 4'($urandom);
        if (ovr_at > 0) begin
            while (cyc < c + ovr_at) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            pulse_start();
            ovr_exp = 1'b1;
        end
        if (rst_at > 0) begin
            while (cyc < c + rst_at) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            #2 reset_n = 1'b0;
            ovr_exp = 1'b0;
            @(posedge clk);
            @(negedge clk);
            #2 reset_n = 1'b1;
            repeat (2) @(negedge clk);
        end else begin
            while (cyc < c + lat + 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic timestep1(input logic [3:0] spk);
        sb_t e;
        int c, lat;
        @(negedge clk);
        for (int i = 0; i < M; i++)
            weights1[i*NB +: NB] = NB'(w1_tab[i]);
        lat = (spk == 4'b0) ? 1 : 3;
        c = cyc;
        e.cur = ref_currents(spk, 1'b1);
        e.done_cyc = c + lat;
        e.spk = spk;
        e.w = 64'(weights1);
        e.zero = (spk == 4'b0);
        spikes1 = spk;
        sbq1.push_back(e);
        $display("timestep N=1: spikes=%b weights=%h expect current=%h at cycle %0d",
                 spk, weights1, e.cur[3:0], e.done_cyc);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        while (cyc < c + lat + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] spk;
        int ovr;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < M; i++) begin
            w_tab[0][i] = 1;
            w_tab[1][i] = 2;
            w_tab[2][i] = 4;
            w_tab[3][i] = 0;
        end
        timestep(4'b1011, 0, 0);
        timestep(4'b0000, 0, 0);
        timestep(4'b1011, 3, 0);
        timestep(4'b0001, 0, 0);
        timestep(4'b1111, 0, 3);
        timestep(4'b0110, 0, 0);

        for (int i = 0; i < M; i++) w1_tab[i] = 3;
        timestep1(4'b1111);
        for (int i = 0; i < M; i++) w1_tab[i] = 1;
        timestep1(4'b0101);
        timestep1(4'b0000);

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < N; k++)
                for (int i = 0; i < M; i++)
                    w_tab[k][i] = $urandom_range(0, 4);
            spk = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
            ovr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (spk == 4'b0) ? 1 : N + 2) : 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            timestep(spk, ovr, 0);
        end

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < M; i++) w1_tab[i] = $urandom_range(0, 5);
            timestep1(4'($urandom));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/current_calc_scheduler.md
# current_calc_scheduler

Sequences one shared input-current calculator across the N neurons of an SNN layer for each timestep. On `start` it latches the layer's input spike vector and issues one calculation per neuron, pipelined one per cycle. It steers that neuron's weight slice into the calculator and captures each registered result into a per-neuron current register. It sits between the timestep controller and the neuron array, replacing N parallel calculators with one.

## Interface
- `N`, default 4: neurons served per timestep (≥1).
- `M`, default 4: input spikes / weights per neuron.
- `Nbits`, default 4: weight and current width.
- `IDXW`, default 2: index width, must satisfy 2^IDXW ≥ N.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse, begins a timestep.
- `input_spikes`  in  M  layer spikes, sampled when `start` is accepted.
- `weights_all`  in  N*M*Nbits  neuron k slice is `[k*M*Nbits +: M*Nbits]`.
- `calc_spikes`  out  M  to calculator; latched spike vector.
- `calc_weights`  out  M*Nbits  to calculator; weight slice of the issuing neuron.
- `calc_enable`  out  1  to calculator enable.
- `calc_current`  in  Nbits  from calculator registered output.
- `currents`  out  N*Nbits  neuron k current at `[k*Nbits +: Nbits]`.
- `neuron_idx`  out  IDXW  index currently issued.
- `busy`  out  1  timestep in progress.
- `done`  out  1  one-cycle pulse, all currents updated.
- `overrun`  out  1  sticky; `start` arrived while not idle.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 latches `input_spikes` into `spk_q`.
  - If `spk_q` would be all-zero, go directly to DONE and clear all `currents` to 0 (zero-spike shortcut; calculator not enabled).
  - Otherwise go to ISSUE with `neuron_idx`=0.
- ISSUE: `calc_enable`=1 and `calc_weights` = slice[`neuron_idx`].
  - Each cycle with `neuron_idx`≥1, capture `calc_current` into `currents[neuron_idx-1]`.
  - `neuron_idx` increments each cycle. After issuing N-1, go to DRAIN.
- DRAIN: `calc_enable`=0; capture `calc_current` into `currents[N-1]`; go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `calc_spikes` = `spk_q` at all times. `calc_weights` = 0 outside ISSUE.
- `busy` = 1 in ISSUE and DRAIN only.
- `neuron_idx` holds 0 outside ISSUE.
- `start` outside IDLE is ignored (no relatch) and sets `overrun`. `overrun` clears only on reset.
- `currents` entries change only on their capture cycle; they hold between timesteps.
- `weights_all` must be stable from `start` until `done`. The block does not latch it.
- No arithmetic is done here: values pass through unmodified. Saturation belongs to the calculator.

## Timing
- Reset (async assert, sync-released use): state IDLE; `spk_q`, `currents`, `neuron_idx`, `calc_enable`, `busy`, `done`, `overrun` all 0.
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..N: ISSUE with idx 0..N-1. Calculator result for idx k appears in cycle k+2.
- Cycle N+1: DRAIN.
- Cycle N+2: DONE, `done`=1. `currents` reflect all N results in this cycle.
- Start-to-`done` latency: N+2 cycles.
- Zero-spike shortcut: `done` in cycle 1, `currents` = 0 in cycle 1.
- Next `start` is acceptable at the earliest in cycle N+3 (back in IDLE).
- N=1: ISSUE lasts one cycle, followed by DRAIN and DONE (latency 3).
- Reset mid-operation: immediate return to IDLE with all outputs 0. Partially captured currents are lost.
- `start` in the DONE cycle: ignored, sets `overrun`.

## Test plan
Bench uses N=4, M=4, Nbits=4, with the real calculator (saturating at 7) attached.
- Weights n0=all 1, n1=all 2, n2=all 4, n3=all 0; spikes 4'b1011; pulse `start` → `calc_enable` high in cycles 1–4, `done` in cycle 6, `currents`=16'h0763, `busy` high cycles 1–5.
- Same weights, spikes 4'b0000 → `done` in cycle 1, `currents`=16'h0000, `calc_enable` never asserted.
- Back-to-back: second `start` pulsed in cycle 3 → ignored, `overrun`=1, first result unchanged. Then `start` in cycle 7 with spikes 4'b0001 → `currents`=16'h0421.
- Assert `reset_n`=0 in cycle 3 of a timestep → `currents`=0, `busy`=0, `done` never pulses. The next `start` completes normally with latency 6.
- Parameter N=1, weight all 3, spikes 4'b1111 → `done` in cycle 3, `currents`=4'h7 (saturated).
